// File: rtl/vec_mem_pkg.sv
// ---------------------------------------------------------------------------
// vec_mem_pkg
// Shared definitions for the vector processor data memories.
//   - VEC_MEM_W / VEC_MEM_AW : default word and address widths.
//   - drain_state_e          : drain controller states (IDLE / DRAIN / DONE).
//   - lane_lsb()             : bit offset of lane `lane` in a packed lane bus.
// No ports (package).
// ---------------------------------------------------------------------------
package vec_mem_pkg;

  localparam int unsigned VEC_MEM_W  = 24;
  localparam int unsigned VEC_MEM_AW = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

  // Lane i of a packed LANES*W bus lives at bits [i*W +: W].
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/vec_mem_window.sv
// ---------------------------------------------------------------------------
// vec_mem_window
// Combinational address-window decode for a vector access of LANES
// consecutive words starting at addr_i.
// Ports:
//   addr_i   in  AW  word address of lane 0
//   in_win_o out 1   whole vector lies inside [BASE, BASE+DEPTH)
//   idx_o    out IW  memory index of lane 0 (addr_i - BASE), valid when in_win_o
// A vector that only partially overlaps the window reports in_win_o = 0.
// ---------------------------------------------------------------------------
module vec_mem_window #(
  parameter int unsigned AW    = 24,
  parameter int unsigned BASE  = 24,
  parameter int unsigned DEPTH = 10000,
  parameter int unsigned LANES = 4,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr_i,
  output logic          in_win_o,
  output logic [IW-1:0] idx_o
);

  // One extra bit so addr + LANES and BASE + DEPTH cannot wrap.
  localparam logic [AW:0] LO_X  = (AW+1)'(BASE);
  localparam logic [AW:0] HI_X  = (AW+1)'(BASE + DEPTH);
  localparam logic [AW:0] LN_X  = (AW+1)'(LANES);

  logic [AW:0] addr_x;
  logic [AW:0] end_x;

  always_comb begin
    addr_x   = {1'b0, addr_i};
    end_x    = addr_x + LN_X;
    in_win_o = (addr_x >= LO_X) && (end_x <= HI_X);
    idx_o    = IW'(addr_i - AW'(BASE));
  end

endmodule

// File: rtl/vec_out_mem.sv
// ---------------------------------------------------------------------------
// vec_out_mem
// Output data memory for the vector processor. Vector stores write up to
// LANES consecutive words (per-lane mask) inside [BASE, BASE+DEPTH); vector
// loads return LANES words one cycle later. A drain port streams every word
// out in index order over valid/ready so results can be dumped without I/O.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we, re, addr      vector write/read enables and lane-0 word address
//   wd, lane_mask     write data (lane i at [i*W +: W]) and per-lane enable
//   rd, rd_valid      registered read data and its one-cycle valid pulse
//   oob_err           one-cycle pulse after an out-of-window access
//   drain_start       start a full-memory drain (accepted in IDLE only)
//   drain_valid/ready drain handshake; drain_data/drain_idx word and index
//   drain_done        one-cycle pulse after the last word is accepted
//   busy              drain in progress (vector accesses are ignored)
// Optional build macro VEC_OUT_MEM_STATS_EN adds:
//   wr_count  [31:0]  saturating count of words written (popcount of mask)
//   oob_count [15:0]  saturating count of oob_err pulses
// ---------------------------------------------------------------------------
module vec_out_mem
  import vec_mem_pkg::*;
#(
  parameter int unsigned W     = VEC_MEM_W,
  parameter int unsigned AW    = VEC_MEM_AW,
  parameter int unsigned DEPTH = 10000,
  parameter int unsigned BASE  = 24,
  parameter int unsigned LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [AW-1:0]            addr,
  input  logic [LANES*W-1:0]       wd,
  input  logic [LANES-1:0]         lane_mask,
  output logic [LANES*W-1:0]       rd,
  output logic                     rd_valid,
  output logic                     oob_err,
  input  logic                     drain_start,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [W-1:0]             drain_data,
  output logic [$clog2(DEPTH)-1:0] drain_idx,
  output logic                     drain_done,
  output logic                     busy
`ifdef VEC_OUT_MEM_STATS_EN
  ,
  output logic [31:0]              wr_count,
  output logic [15:0]              oob_count
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic          in_win;
  logic [IW-1:0] idx;

  vec_mem_window #(
    .AW    (AW),
    .BASE  (BASE),
    .DEPTH (DEPTH),
    .LANES (LANES),
    .IW    (IW)
  ) u_window (
    .addr_i   (addr),
    .in_win_o (in_win),
    .idx_o    (idx)
  );

  logic [W-1:0] mem [DEPTH];

  drain_state_e  state_q, state_d;
  logic [IW-1:0] drain_idx_q, drain_idx_d;
  logic [LANES*W-1:0] rd_q, rd_d;
  logic rd_valid_q, oob_q;

  // Vector accesses only act in IDLE; a drain owns the memory.
  logic idle, acc_wr, acc_rd, oob_evt;
  assign idle    = (state_q == ST_IDLE);
  assign acc_wr  = !rst && idle && we && in_win;
  assign acc_rd  = idle && re;
  assign oob_evt = idle && (we || re) && !in_win;

  // Per-lane read mux; an out-of-window read returns zeros.
  logic [W-1:0] wd_lane [LANES];
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign wd_lane[gi] = wd[lane_lsb(gi, W) +: W];
    assign rd_d[lane_lsb(gi, W) +: W] = in_win ? mem[idx + IW'(gi)] : '0;
  end

  // Memory array: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (acc_wr && lane_mask[i]) begin
        mem[idx + IW'(i)] <= wd_lane[i];
      end
    end
  end

  // Drain controller: next-state logic.
  always_comb begin
    state_d     = state_q;
    drain_idx_d = drain_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          state_d     = ST_DRAIN;
          drain_idx_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_ready) begin
          if (drain_idx_q == IW'(DEPTH - 1)) begin
            // Park the index at 0 so it never exceeds DEPTH-1.
            state_d     = ST_DONE;
            drain_idx_d = '0;
          end else begin
            drain_idx_d = drain_idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d     = ST_IDLE;
        drain_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_idx_q <= '0;
      rd_q        <= '0;
      rd_valid_q  <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_idx_q <= drain_idx_d;
      rd_valid_q  <= acc_rd;
      oob_q       <= oob_evt;
      if (acc_rd) begin
        // Reads see the array before this edge's write: read-first.
        rd_q <= rd_d;
      end
    end
  end

  assign rd          = rd_q;
  assign rd_valid    = rd_valid_q;
  assign oob_err     = oob_q;
  assign drain_valid = (state_q == ST_DRAIN);
  assign drain_data  = drain_valid ? mem[drain_idx_q] : '0;
  assign drain_idx   = drain_idx_q;
  assign drain_done  = (state_q == ST_DONE);
  assign busy        = !idle;

`ifdef VEC_OUT_MEM_STATS_EN
  logic [31:0] wr_count_q;
  logic [15:0] oob_count_q;
  logic [32:0] wr_sum;

  assign wr_sum = {1'b0, wr_count_q} + 33'($countones(lane_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q  <= '0;
      oob_count_q <= '0;
    end else begin
      if (acc_wr) begin
        wr_count_q <= wr_sum[32] ? '1 : wr_sum[31:0];
      end
      if (oob_evt && (oob_count_q != '1)) begin
        oob_count_q <= oob_count_q + 1'b1;
      end
    end
  end

  assign wr_count  = wr_count_q;
  assign oob_count = oob_count_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: doc/vec_out_mem.md
Name: vec_out_mem

Overview:
- Parametrised output data memory for the vector processor. Holds result words written by vector stores inside a fixed address window [BASE, BASE+DEPTH).
- Accepts up to LANES consecutive words per write with a per-lane mask, and gives registered readback of LANES words.
- A drain port streams the whole memory out over a valid/ready handshake, so the host/testbench can dump results without simulator file I/O.

Parameters:
- W, 24, word width in bits.
- AW, 24, address width in bits.
- DEPTH, 10000, number of words in the window.
- BASE, 24, first word address mapped to index 0.
- LANES, 4, words per vector access (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- we  in  1  vector write enable
- re  in  1  vector read enable
- addr  in  AW  word address of lane 0
- wd  in  LANES*W  write data; lane i occupies bits [i*W +: W]
- lane_mask  in  LANES  per-lane write enable
- rd  out  LANES*W  read data
- rd_valid  out  1  rd valid pulse
- oob_err  out  1  out-of-window access pulse
- drain_start  in  1  start full-memory drain
- drain_valid  out  1  drain word valid
- drain_ready  in  1  consumer accepts drain word
- drain_data  out  W  drain word
- drain_idx  out  $clog2(DEPTH)  index of drain_data
- drain_done  out  1  one-cycle pulse after last word accepted
- busy  out  1  drain in progress

Behaviour:
- Reset: rd=0, rd_valid=0, oob_err=0, drain_valid=0, drain_idx=0, drain_done=0, busy=0, FSM=IDLE. Memory contents are not cleared.
- Window test (combinational): in_win = addr ≥ BASE && addr+LANES ≤ BASE+DEPTH, evaluated at AW+1 bits to avoid overflow. idx = addr − BASE.
- Index computation is combinational from the current addr. No registered address is used for writes.
- Write (IDLE only): on a posedge with we && in_win, mem[idx+i] ← lane i for every lane with lane_mask[i]=1. Masked lanes are unchanged.
- Read (IDLE only): on a posedge with re && in_win, rd ← mem[idx..idx+LANES−1] and rd_valid=1 the next cycle (latency 1). rd_valid is a single-cycle pulse; rd holds its value until the next read.
- Simultaneous we/re to overlapping words: read-first. rd returns the pre-write data.
- Out-of-window: (we||re) && !in_win → access dropped, oob_err=1 next cycle for one cycle. An OOB read gives rd=0 with rd_valid=1. A partial overlap of the window counts as fully OOB.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE→DRAIN on drain_start: drain_idx=0, busy=1.
  - In DRAIN: drain_valid=1 and drain_data=mem[drain_idx] (combinational from the index register). drain_idx increments on drain_valid && drain_ready.
  - Handshake: drain_data must stay stable while drain_valid && !drain_ready.
  - DRAIN→DONE when word DEPTH−1 is accepted.
  - DONE: drain_done=1, drain_valid=0. DONE→IDLE next cycle, with busy=0 on that transition.
- While busy: we, re and drain_start are ignored and raise no oob_err.
- rst mid-drain: returns to IDLE next edge, all outputs take reset values, and no drain_done is issued.

Optional Feature:
- Macro VEC_OUT_MEM_STATS_EN.
- Defined: adds output wr_count [31:0]. It increments by popcount(lane_mask) on every accepted in-window write, saturates at 2^32−1, and clears on rst.
- Also adds output oob_count [15:0], which counts oob_err pulses and saturates.
- Undefined: neither port nor the logic exists.

Decomposition:
- Shared package vec_mem_pkg: drain FSM enum (IDLE/DRAIN/DONE), lane slice helper function, and the default W/AW constants used by the other vector memories.
- One natural sub-module, vec_mem_window: pure combinational in_win/idx decode from addr, BASE, DEPTH, LANES. It is reused by the input memory.

Test Plan:
- Write addr=24, lanes 0x000001..0x000004, mask 4'b1111; read addr=24 → rd lanes 1,2,3,4, rd_valid exactly 1 cycle after re.
- Mask test: write addr=30, mask 4'b0101, wd lanes 0xAAAAAA; read → lanes 0 and 2 = 0xAAAAAA, lanes 1 and 3 keep prior values.
- Boundaries: write addr=10020 accepted (last full vector). addr=10021, addr=23 and addr=0xFFFFFF → no write, oob_err pulse, OOB read gives rd=0.
- Read-first: same-cycle we/re at addr=40 with new data 0x123456 over old 0x000007 → rd lane 0 = 0x000007; a second read gives 0x123456.
- Drain: preload, drain_start, drain_ready toggling 1/0 → DEPTH words in index order, data stable under stall, drain_done one cycle after index 9999 accepted, busy then 0. A we issued during the drain leaves memory unchanged.
- Reset mid-drain at drain_idx=500 → next cycle busy=0, drain_valid=0, no drain_done; a new drain restarts at index 0 with contents intact.
